gelato_wb_arbiter: RTL and testbench

// - Producer side of the register write-back interface. Collects results from N_SRC execution units.
// - Issues at most one write-back per cycle to the scoreboard and register file.
// - Each source has a 1-entry holding slot. A round-robin arbiter picks among occupied slots.
// - The winner is registered onto the reg_wb outputs. The scoreboard clears the busy bit on that pulse.

---
 rtl/gelato_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_gelato_wb_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_wb_arbiter.sv
// Register write-back arbiter: N_SRC one-entry holding slots, round-robin pick, one registered write-back per cycle.
// Optional stall perf counter enabled by defining GELATO_WB_STALL_CNT_EN.
module gelato_wb_arbiter #(
  parameter int N_SRC       = 4,
  parameter int NUM_WARPS   = 32,
  parameter int NUM_THREADS = 32,
  parameter int REG_W       = 5,
  parameter int DATA_W      = 32,
  localparam int WARP_W     = $clog2(NUM_WARPS)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  rdy,
  input  logic [N_SRC-1:0]                      src_valid,
  output logic [N_SRC-1:0]                      src_ready,
  input  logic [N_SRC*WARP_W-1:0]               src_warp_id,
  input  logic [N_SRC*REG_W-1:0]                src_rd,
  input  logic [N_SRC*NUM_THREADS-1:0]          src_mask,
  input  logic [N_SRC*NUM_THREADS*DATA_W-1:0]   src_data,
  output logic                                  reg_wb_valid,
  output logic [WARP_W-1:0]                     reg_wb_warp_id,
  output logic [REG_W-1:0]                      reg_wb_rd,
  output logic [NUM_THREADS-1:0]                reg_wb_mask,
  output logic [NUM_THREADS*DATA_W-1:0]         reg_wb_data,
  output logic [31:0]                           wb_stall_cnt
);

  localparam int ROW_W = NUM_THREADS * DATA_W;
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef struct packed {
    logic [WARP_W-1:0]      warp;
    logic [REG_W-1:0]       rd;
    logic [NUM_THREADS-1:0] mask;
    logic [ROW_W-1:0]       data;
  } result_t;

  result_t          srcRes [N_SRC];
  result_t          slotRes_q [N_SRC];
  logic [N_SRC-1:0] slotValid_q, slotValid_d;
  logic [IDX_W-1:0] rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0] winIdx;
  logic [IDX_W:0]   cand;
  logic [N_SRC-1:0] grant, accept;
  logic             anyGrant;
  result_t          winRes;
  logic             wbValid_q, wbValid_d;
  result_t          wbRes_q, wbRes_d;

  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      srcRes[i].warp = src_warp_id[i*WARP_W +: WARP_W];
      srcRes[i].rd   = src_rd[i*REG_W +: REG_W];
      srcRes[i].mask = src_mask[i*NUM_THREADS +: NUM_THREADS];
      srcRes[i].data = src_data[i*ROW_W +: ROW_W];
    end
  end

  // First occupied slot at or after rrPtr_q, wrapping; nothing is granted while frozen.
  always_comb begin
    cand     = '0;
    winIdx   = '0;
    anyGrant = 1'b0;
    grant    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = {1'b0, rrPtr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_SRC)) cand = cand - (IDX_W+1)'(N_SRC);
      if (rdy && !anyGrant && slotValid_q[cand[IDX_W-1:0]]) begin
        anyGrant = 1'b1;
        winIdx   = cand[IDX_W-1:0];
      end
    end
    if (anyGrant) grant[winIdx] = 1'b1;
    winRes = slotRes_q[winIdx];
  end

  assign src_ready = {N_SRC{rdy}} & (~slotValid_q | grant);
  assign accept    = src_valid & src_ready;

  // A granted slot that is also reloaded stays occupied; drops still consume the grant but emit no pulse.
  always_comb begin
    slotValid_d = (slotValid_q & ~grant) | accept;
    rrPtr_d     = rrPtr_q;
    wbValid_d   = wbValid_q;
    wbRes_d     = wbRes_q;
    if (anyGrant) begin
      rrPtr_d   = (winIdx == IDX_W'(N_SRC-1)) ? '0 : winIdx + 1'b1;
      wbValid_d = (winRes.rd != '0) && (winRes.mask != '0);
      wbRes_d   = winRes;
    end else if (rdy) begin
      wbValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slotValid_q <= '0;
      rrPtr_q     <= '0;
      wbValid_q   <= 1'b0;
      wbRes_q     <= '0;
    end else begin
      slotValid_q <= slotValid_d;
      rrPtr_q     <= rrPtr_d;
      wbValid_q   <= wbValid_d;
      wbRes_q     <= wbRes_d;
    end
  end

  // Slot payloads need no reset: they are only observed through slotValid_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (accept[i]) slotRes_q[i] <= srcRes[i];
    end
  end

  assign reg_wb_valid   = wbValid_q & rdy;
  assign reg_wb_warp_id = wbRes_q.warp;
  assign reg_wb_rd      = wbRes_q.rd;
  assign reg_wb_mask    = wbRes_q.mask;
  assign reg_wb_data    = wbRes_q.data;

`ifdef GELATO_WB_STALL_CNT_EN
  logic [31:0] stallCnt_q;

  // Two or more occupied slots means at least one lost arbitration this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if (rdy && ($countones(slotValid_q) > 1) && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign wb_stall_cnt = stallCnt_q;
`else
  assign wb_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_gelato_wb_arbiter.sv
// Self-checking bench for gelato_wb_arbiter: directed vector table, hand-written rdy/reset sequences,
// and randomized traffic compared against a slot/turn-order reference model.
module tb_gelato_wb_arbiter;

   localparam int NS   = 4;
   localparam int NT   = 32;
   localparam int DW   = 32;
   localparam int RW   = 5;
   localparam int WW   = 5;
   localparam int ROWW = NT * DW;

`ifdef GELATO_WB_STALL_CNT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   typedef struct packed {
      logic [WW-1:0]   warp;
      logic [RW-1:0]   rd;
      logic [NT-1:0]   mask;
      logic [ROWW-1:0] data;
   } res_t;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic [3:0]  valid;
      logic [19:0] rds;
      logic [3:0]  expReady;
      logic        expValid;
      int          expSrc;
      logic [4:0]  expRd;
      int          expStall;
   } vec_t;

   logic                clk = 1'b0;
   logic                rst, rdy;
   logic [NS-1:0]       srcValid;
   logic [NS-1:0]       srcReady;
   logic [NS*WW-1:0]    srcWarp;
   logic [NS*RW-1:0]    srcRd;
   logic [NS*NT-1:0]    srcMask;
   logic [NS*ROWW-1:0]  srcData;
   logic                wbValid;
   logic [WW-1:0]       wbWarp;
   logic [RW-1:0]       wbRd;
   logic [NT-1:0]       wbMask;
   logic [ROWW-1:0]     wbData;
   logic [31:0]         stallCnt;

   int   vectors = 0;
   int   miscompares = 0;
   res_t drive [NS];
   vec_t vecs [$];

   // Reference model state: slot contents, turn pointer, pending pulse, stall count.
   res_t        mSlot [NS];
   bit          mOcc [NS];
   int          mRr;
   bit          mPendV;
   res_t        mPend;
   logic [31:0] mStall;

   gelato_wb_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .src_valid     (srcValid),
      .src_ready     (srcReady),
      .src_warp_id   (srcWarp),
      .src_rd        (srcRd),
      .src_mask      (srcMask),
      .src_data      (srcData),
      .reg_wb_valid  (wbValid),
      .reg_wb_warp_id(wbWarp),
      .reg_wb_rd     (wbRd),
      .reg_wb_mask   (wbMask),
      .reg_wb_data   (wbData),
      .wb_stall_cnt  (stallCnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   function automatic logic [19:0] R(input logic [4:0] r0, r1, r2, r3);
      return {r3, r2, r1, r0};
   endfunction

   // Directed payload: warp 3+src, full mask, each thread word tags source, rd and thread index.
   function automatic res_t tableRes(input int src, input logic [4:0] rd);
      res_t r;
      r.warp = WW'(3 + src);
      r.rd   = rd;
      r.mask = '1;
      for (int t = 0; t < NT; t++) r.data[t*DW +: DW] = {8'(src), 3'b000, rd, 16'(t)};
      return r;
   endfunction

   function automatic res_t randRes();
      res_t r;
      r.warp = WW'($urandom);
      r.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      r.mask = ($urandom_range(0, 7) == 0) ? '0 : NT'($urandom);
      for (int t = 0; t < NT; t++) r.data[t*DW +: DW] = $urandom;
      return r;
   endfunction

   function automatic void addVec(input logic r, y, input logic [3:0] v, input logic [19:0] rds,
                                  input logic [3:0] eRdy, input logic eV, input int eSrc,
                                  input logic [4:0] eRd, input int eStall);
      vec_t x;
      x.rst = r; x.rdy = y; x.valid = v; x.rds = rds;
      x.expReady = eRdy; x.expValid = eV; x.expSrc = eSrc; x.expRd = eRd; x.expStall = eStall;
      vecs.push_back(x);
   endfunction

   // Drive one cycle of inputs just after a falling edge and let combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic y, input logic [3:0] v);
      rst = r;
      rdy = y;
      srcValid = v;
      for (int i = 0; i < NS; i++) begin
         srcWarp[i*WW +: WW]     = drive[i].warp;
         srcRd[i*RW +: RW]       = drive[i].rd;
         srcMask[i*NT +: NT]     = drive[i].mask;
         srcData[i*ROWW +: ROWW] = drive[i].data;
      end
      #1;
   endtask

   task automatic nextCycle();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
      end
   endtask

   task automatic chkData(input logic [ROWW-1:0] act, input logic [ROWW-1:0] exp);
      int bad;
      bad = -1;
      for (int t = NT - 1; t >= 0; t--) if (act[t*DW +: DW] !== exp[t*DW +: DW]) bad = t;
      if (bad >= 0) begin
         miscompares++;
         $display("[TB] FAIL wb_data thread %0d at %0t: got %h, want %h",
                  bad, $time, act[bad*DW +: DW], exp[bad*DW +: DW]);
      end
   endtask

   task automatic checkOutput(input logic [3:0] eReady, input logic eValid, input res_t eRes,
                              input logic [31:0] eStall);
      vectors++;
      chk("src_ready", 64'(srcReady), 64'(eReady));
      chk("wb_valid", 64'(wbValid), 64'(eValid));
      if (eValid) begin
         chk("wb_warp", 64'(wbWarp), 64'(eRes.warp));
         chk("wb_rd", 64'(wbRd), 64'(eRes.rd));
         chk("wb_mask", 64'(wbMask), 64'(eRes.mask));
         chkData(wbData, eRes.data);
      end
      chk("stall_cnt", 64'(stallCnt), 64'(eStall));
   endtask

   function automatic logic [31:0] expStall(input int v);
      return STALL_EN ? 32'(v) : 32'd0;
   endfunction

   // Random traffic against the model: expected outputs from the pre-edge state, then the edge update.
   task automatic runRandom(input int cycles);
      logic       r, y;
      logic [3:0] v, eReady;
      int         win, occ;
      for (int i = 0; i < NS; i++) mOcc[i] = 1'b0;
      mRr = 0; mPendV = 1'b0; mPend = '0; mStall = '0;
      for (int c = 0; c < cycles; c++) begin
         r = ($urandom_range(0, 99) == 0);
         y = ($urandom_range(0, 4) != 0);
         v = 4'($urandom);
         for (int i = 0; i < NS; i++) drive[i] = randRes();
         applyStimulus(r, y, v);

         win = -1;
         if (y) begin
            for (int k = 0; k < NS; k++) begin
               if (win < 0 && mOcc[(mRr + k) % NS]) win = (mRr + k) % NS;
            end
         end
         for (int i = 0; i < NS; i++) eReady[i] = y && (!mOcc[i] || win == i);
         checkOutput(eReady, mPendV && y, mPend, STALL_EN ? mStall : 32'd0);

         if (r) begin
            for (int i = 0; i < NS; i++) mOcc[i] = 1'b0;
            mRr = 0; mPendV = 1'b0; mStall = '0;
         end else if (y) begin
            occ = 0;
            for (int i = 0; i < NS; i++) occ += int'(mOcc[i]);
            if (occ >= 2 && mStall != 32'hFFFF_FFFF) mStall = mStall + 32'd1;
            if (win >= 0) begin
               mPend  = mSlot[win];
               mPendV = (mSlot[win].rd != 0) && (mSlot[win].mask != 0);
               mOcc[win] = 1'b0;
               mRr = (win + 1) % NS;
            end else begin
               mPendV = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
               if (v[i] && eReady[i]) begin
                  mOcc[i]  = 1'b1;
                  mSlot[i] = drive[i];
               end
            end
         end
         nextCycle();
      end
   endtask

   initial begin
      // Directed table; each row's expectations describe the cycle before its edge.
      addVec(0,1,4'b0001,R(7,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,0,7, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(1,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b1111,R(1,2,3,4), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b0001,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b0011,1,0,1, 1);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b0111,1,1,2, 2);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,2,3, 3);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,3,4, 3);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 3);
      addVec(1,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 3);
      addVec(0,1,4'b0010,R(0,10,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0010,R(0,11,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0010,R(0,12,0,0), 4'b1111,1,1,10, 0);
      addVec(0,1,4'b0110,R(0,13,20,0),4'b1111,1,1,11, 0);
      addVec(0,1,4'b0110,R(0,14,21,0),4'b1101,1,1,12, 0);
      addVec(0,1,4'b0110,R(0,14,22,0),4'b1011,1,2,20, 1);
      addVec(0,1,4'b0110,R(0,15,22,0),4'b1101,1,1,13, 2);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1011,1,2,21, 3);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,1,14, 4);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,2,22, 4);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 4);
      addVec(1,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 4);
      addVec(0,1,4'b0001,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0001,R(4,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,0,4, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(1,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0101,R(5,0,9,0), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1011,0,0,0, 0);
      for (int k = 0; k < 5; k++) addVec(0,0,4'b0000,R(0,0,0,0), 4'b0000,0,0,0, 1);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,0,5, 1);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,2,9, 1);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 1);
      addVec(1,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 1);
      addVec(0,1,4'b1111,R(1,2,3,4), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b0001,0,0,0, 0);
      addVec(1,1,4'b0000,R(0,0,0,0), 4'b0011,1,0,1, 1);
      addVec(0,1,4'b1001,R(8,0,0,9), 4'b1111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b0111,0,0,0, 0);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,0,8, 1);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,1,3,9, 1);
      addVec(0,1,4'b0000,R(0,0,0,0), 4'b1111,0,0,0, 1);

      for (int i = 0; i < NS; i++) drive[i] = tableRes(i, 5'd0);
      applyStimulus(1'b1, 1'b1, 4'b0000);
      nextCycle();
      nextCycle();

      // Reset state: everything ready, no pulse, zeroed write-back fields and counter.
      applyStimulus(1'b0, 1'b1, 4'b0000);
      checkOutput(4'b1111, 1'b0, tableRes(0, 5'd0), 32'd0);
      chk("reset_wb_rd", 64'(wbRd), 64'd0);
      chk("reset_wb_mask", 64'(wbMask), 64'd0);
      chk("reset_wb_warp", 64'(wbWarp), 64'd0);
      chkData(wbData, '0);
      nextCycle();

      // Frozen: a source offering a result while rdy=0 must not be accepted.
      drive[3] = tableRes(3, 5'd17);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b0, 4'b1000);
         checkOutput(4'b0000, 1'b0, drive[3], 32'd0);
         nextCycle();
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b0, 1'b1, 4'b0000);
         checkOutput(4'b1111, 1'b0, drive[3], 32'd0);
         nextCycle();
      end

      foreach (vecs[n]) begin
         for (int i = 0; i < NS; i++) drive[i] = tableRes(i, vecs[n].rds[i*5 +: 5]);
         applyStimulus(vecs[n].rst, vecs[n].rdy, vecs[n].valid);
         checkOutput(vecs[n].expReady, vecs[n].expValid, tableRes(vecs[n].expSrc, vecs[n].expRd),
                     expStall(vecs[n].expStall));
         nextCycle();
      end

      applyStimulus(1'b1, 1'b1, 4'b0000);
      nextCycle();
      runRandom(600);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
